pcie_rx_detect_ctrl: RTL and testbench
======================================

PCIE_RX_DETECT_CTRL -- requirements
Module: pcie_rx_detect_ctrl

Interface
REQ-001 SHALL have parameter MAX_NUM_LANES, default 4; number of lanes, legal 1..16.
REQ-002 SHALL have parameter QUIET_CYCLES, default 1200; clocks spent in QUIET before each detect pulse.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256; clocks to wait for PhyStatus per detect pass.
REQ-004 SHALL have parameter MAX_RETRIES, default 2; allowed re-detects after a failed pass.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-006 SHALL have port en_i  in  1  level; a rising edge starts detection, low aborts.
REQ-007 SHALL have port phy_phystatus_i  in  MAX_NUM_LANES  per-lane PhyStatus pulse.
REQ-008 SHALL have port phy_rxstatus_i  in  3*MAX_NUM_LANES  per-lane RxStatus; lane i at bits [3i+2:3i].
REQ-009 SHALL have port phy_txdetectrx_o  out  1  PIPE TxDetectRx request.
REQ-010 SHALL have port lane_detected_o  out  MAX_NUM_LANES  final receiver-present mask.
REQ-011 SHALL have port num_active_lanes_o  out  6  negotiated width (0,1,2,4,8,16).
REQ-012 SHALL have ports busy_o, detect_done_o, detect_fail_o  out  1 each  status flags.

Function
REQ-013 SHALL implement states IDLE, QUIET, DETECT, EVAL, DONE, FAIL.
REQ-014 IDLE SHALL go to QUIET on an en_i rising edge (en_i high now, low the previous cycle), clearing masks and the retry counter.
REQ-015 QUIET SHALL count QUIET_CYCLES clocks, then go to DETECT with the responded and pass masks cleared.
REQ-016 DETECT SHALL drive phy_txdetectrx_o=1; it is 0 in all other states.
REQ-017 In DETECT, a lane i with phy_phystatus_i[i]=1 and responded[i]=0 SHALL set responded[i] and set pass[i]=(rxstatus lane i == 3'b011); later pulses on that lane are ignored.
REQ-018 DETECT SHALL exit to EVAL when all lanes have responded or TIMEOUT_CYCLES clocks elapse; lanes with no response count as not detected.
REQ-019 A PhyStatus pulse in the same cycle as timeout SHALL be captured before EVAL.
REQ-020 EVAL (one cycle) with pass[0]=0 SHALL go to QUIET and increment retries if retries<MAX_RETRIES, else go to FAIL.
REQ-021 EVAL with pass all-ones SHALL commit lane_detected_o=pass and go to DONE.
REQ-022 EVAL with a partial pass (pass[0]=1, not all-ones) on the first partial SHALL store pass as first_mask and rerun QUIET then DETECT; this does not consume a retry.
REQ-023 On the second partial (or any pass after first_mask is stored), EVAL SHALL commit lane_detected_o=pass AND first_mask and go to DONE (go to FAIL if bit 0 of the result is 0).
REQ-024 num_active_lanes_o SHALL be the largest w in {1,2,4,8,16}, w<=MAX_NUM_LANES, with lane_detected_o[w-1:0] all ones; 0 if lane 0 is clear; registered, valid in DONE.
REQ-025 busy_o SHALL be 1 in QUIET, DETECT and EVAL; detect_done_o SHALL be 1 only in DONE; detect_fail_o SHALL be 1 only in FAIL.
REQ-026 DONE and FAIL SHALL hold their outputs until en_i goes low, then go to IDLE.
REQ-027 en_i low in any state SHALL force IDLE on the next clock and clear phy_txdetectrx_o, lane_detected_o, num_active_lanes_o and all flags.
REQ-028 Counters SHALL saturate and never wrap.

Reset
REQ-029 While rst_ni=0, the state SHALL be IDLE and every output, mask and counter SHALL be 0, asynchronously.
REQ-030 Deasserting rst_ni while en_i=1 SHALL NOT start detection; an en_i rising edge is required.

Verification (N=4, QUIET=8, TIMEOUT=16, RETRIES=2)
REQ-031 All 4 lanes pulse PhyStatus with 3'b011 on DETECT cycle 3 -> txdetectrx high for 3 cycles, then DONE with mask 4'b1111 and width 4.
REQ-032 Two passes where lanes 0-2 answer 011 and lane 3 is silent -> second QUIET/DETECT pass, then mask 4'b0111 and width 2.
REQ-033 No PhyStatus at all -> 3 DETECT windows of 16 cycles each, then FAIL with width 0.
REQ-034 Lane 3 PhyStatus in the same cycle as timeout -> lane 3 captured, mask 4'b1111.
REQ-035 en_i dropped mid-DETECT -> txdetectrx is 0 and state is IDLE next cycle; rst_ni pulsed mid-QUIET -> all outputs 0 immediately.

Source files
------------

// File: rtl/pcie_rx_detect_ctrl.sv
// Receiver-detect sequencer: QUIET, then pulse TxDetectRx and collect per-lane PhyStatus/RxStatus, retrying or re-running for width.
// Result registered on the EVAL->DONE transition; no backpressure, en_i low aborts to IDLE on the next clock.
module pcie_rx_detect_ctrl #(
  parameter int MAX_NUM_LANES  = 4,
  parameter int QUIET_CYCLES   = 1200,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [MAX_NUM_LANES-1:0]   phy_phystatus_i,
  input  logic [3*MAX_NUM_LANES-1:0] phy_rxstatus_i,
  output logic                       phy_txdetectrx_o,
  output logic [MAX_NUM_LANES-1:0]   lane_detected_o,
  output logic [5:0]                 num_active_lanes_o,
  output logic                       busy_o,
  output logic                       detect_done_o,
  output logic                       detect_fail_o
);

  localparam int N  = MAX_NUM_LANES;
  localparam int QW = (QUIET_CYCLES < 2) ? 1 : $clog2(QUIET_CYCLES);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [QW-1:0] QLAST = QW'(QUIET_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {IDLE, QUIET, DETECT, EVAL, DONE, FAIL} state_t;

  state_t        state_q, state_d;
  logic          en_q;
  logic [QW-1:0] quiet_cnt_q, quiet_cnt_d;
  logic [TW-1:0] det_cnt_q, det_cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [N-1:0]  responded_q, responded_d;
  logic [N-1:0]  pass_q, pass_d;
  logic [N-1:0]  first_mask_q, first_mask_d;
  logic          first_vld_q, first_vld_d;
  logic [N-1:0]  lane_det_q, lane_det_d;
  logic [5:0]    num_act_q, num_act_d;

  logic [N-1:0]  rx_ok, hit, resp_cap, pass_cap, combined;

  // Largest power-of-two width whose low lanes are all present.
  function automatic logic [5:0] width_of(input logic [N-1:0] m);
    logic [5:0] w;
    logic       ok;
    int         lw;
    w = '0;
    for (int k = 0; k < 5; k++) begin
      lw = 1 << k;
      ok = (lw <= N);
      for (int j = 0; j < N; j++) begin
        if (j < lw && !m[j]) ok = 1'b0;
      end
      if (ok) w = 6'(lw);
    end
    return w;
  endfunction

  always_comb begin
    rx_ok = '0;
    for (int i = 0; i < N; i++) begin
      rx_ok[i] = (phy_rxstatus_i[3*i +: 3] == 3'b011);
    end
  end

  assign hit      = phy_phystatus_i & ~responded_q;
  assign resp_cap = responded_q | hit;
  assign pass_cap = pass_q | (hit & rx_ok);
  assign combined = pass_q & first_mask_q;

  always_comb begin
    state_d      = state_q;
    quiet_cnt_d  = quiet_cnt_q;
    det_cnt_d    = det_cnt_q;
    retry_d      = retry_q;
    responded_d  = responded_q;
    pass_d       = pass_q;
    first_mask_d = first_mask_q;
    first_vld_d  = first_vld_q;
    lane_det_d   = lane_det_q;
    num_act_d    = num_act_q;

    if (!en_i) begin
      state_d      = IDLE;
      quiet_cnt_d  = '0;
      det_cnt_d    = '0;
      retry_d      = '0;
      responded_d  = '0;
      pass_d       = '0;
      first_mask_d = '0;
      first_vld_d  = 1'b0;
      lane_det_d   = '0;
      num_act_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!en_q) begin
            state_d      = QUIET;
            quiet_cnt_d  = '0;
            retry_d      = '0;
            responded_d  = '0;
            pass_d       = '0;
            first_mask_d = '0;
            first_vld_d  = 1'b0;
            lane_det_d   = '0;
            num_act_d    = '0;
          end
        end
        QUIET: begin
          if (quiet_cnt_q == QLAST) begin
            state_d     = DETECT;
            det_cnt_d   = '0;
            responded_d = '0;
            pass_d      = '0;
          end else begin
            quiet_cnt_d = quiet_cnt_q + QW'(1);
          end
        end
        DETECT: begin
          // Pulses on the final timeout cycle still land in the masks.
          responded_d = resp_cap;
          pass_d      = pass_cap;
          if ((&resp_cap) || (det_cnt_q == TLAST)) begin
            state_d = EVAL;
          end else begin
            det_cnt_d = det_cnt_q + TW'(1);
          end
        end
        EVAL: begin
          quiet_cnt_d = '0;
          if (first_vld_q) begin
            if (combined[0]) begin
              lane_det_d = combined;
              num_act_d  = width_of(combined);
              state_d    = DONE;
            end else begin
              state_d = FAIL;
            end
          end else if (!pass_q[0]) begin
            if (retry_q < RMAX) begin
              retry_d = retry_q + RW'(1);
              state_d = QUIET;
            end else begin
              state_d = FAIL;
            end
          end else if (&pass_q) begin
            lane_det_d = pass_q;
            num_act_d  = width_of(pass_q);
            state_d    = DONE;
          end else begin
            // First partial result: remember it and rerun once to confirm.
            first_mask_d = pass_q;
            first_vld_d  = 1'b1;
            state_d      = QUIET;
          end
        end
        DONE, FAIL: state_d = state_q;
        default:    state_d = IDLE;
      endcase
    end
  end

  // en_q resets high so a reset release with en_i already high is not an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      en_q         <= 1'b1;
      quiet_cnt_q  <= '0;
      det_cnt_q    <= '0;
      retry_q      <= '0;
      responded_q  <= '0;
      pass_q       <= '0;
      first_mask_q <= '0;
      first_vld_q  <= 1'b0;
      lane_det_q   <= '0;
      num_act_q    <= '0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_i;
      quiet_cnt_q  <= quiet_cnt_d;
      det_cnt_q    <= det_cnt_d;
      retry_q      <= retry_d;
      responded_q  <= responded_d;
      pass_q       <= pass_d;
      first_mask_q <= first_mask_d;
      first_vld_q  <= first_vld_d;
      lane_det_q   <= lane_det_d;
      num_act_q    <= num_act_d;
    end
  end

  assign phy_txdetectrx_o   = (state_q == DETECT);
  assign busy_o             = (state_q == QUIET) || (state_q == DETECT) || (state_q == EVAL);
  assign detect_done_o      = (state_q == DONE);
  assign detect_fail_o      = (state_q == FAIL);
  assign lane_detected_o    = lane_det_q;
  assign num_active_lanes_o = num_act_q;

endmodule

// File: tb/tb_pcie_rx_detect_ctrl.sv
// Randomized bench for pcie_rx_detect_ctrl: per-pass lane response tables drive the PHY side,
// a pass-level outcome model predicts window lengths, pass count and final result.
module tb_pcie_rx_detect_ctrl;
  localparam int N  = 4;
  localparam int QC = 8;
  localparam int TC = 16;
  localparam int RC = 2;
  localparam int NP = 5;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           en_i = 1'b0;
  logic [N-1:0]   phy_phystatus_i = '0;
  logic [3*N-1:0] phy_rxstatus_i = '0;
  logic           phy_txdetectrx_o;
  logic [N-1:0]   lane_detected_o;
  logic [5:0]     num_active_lanes_o;
  logic           busy_o, detect_done_o, detect_fail_o;

  int n_chk = 0;
  int n_err = 0;

  // Per pass, per lane: first PhyStatus offset in the DETECT window (0 = silent),
  // whether that response is 011, and an optional later duplicate pulse.
  int off_t [NP][N];
  int dup_t [NP][N];
  bit ok_t  [NP][N];

  always #5 clk_i = ~clk_i;

  pcie_rx_detect_ctrl #(
    .MAX_NUM_LANES (N),
    .QUIET_CYCLES  (QC),
    .TIMEOUT_CYCLES(TC),
    .MAX_RETRIES   (RC)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .en_i              (en_i),
    .phy_phystatus_i   (phy_phystatus_i),
    .phy_rxstatus_i    (phy_rxstatus_i),
    .phy_txdetectrx_o  (phy_txdetectrx_o),
    .lane_detected_o   (lane_detected_o),
    .num_active_lanes_o(num_active_lanes_o),
    .busy_o            (busy_o),
    .detect_done_o     (detect_done_o),
    .detect_fail_o     (detect_fail_o)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({phy_txdetectrx_o, lane_detected_o, num_active_lanes_o,
                 busy_o, detect_done_o, detect_fail_o});
  endfunction

  function automatic logic [2:0] bad_rx();
    int v;
    v = $urandom_range(0, 6);
    if (v >= 3) v++;
    return 3'(v);
  endfunction

  function automatic int width_model(input int m);
    if ((m & 1) == 0)   return 0;
    if ((m & 3) != 3)   return 1;
    if ((m & 15) != 15) return 2;
    return 4;
  endfunction

  task automatic clear_tables();
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < N; i++) begin
        off_t[p][i] = 0;
        dup_t[p][i] = 0;
        ok_t[p][i]  = 1'b0;
      end
  endtask

  task automatic random_tables();
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < N; i++) begin
        off_t[p][i] = ($urandom_range(0, 4) != 0) ? int'($urandom_range(1, TC)) : 0;
        ok_t[p][i]  = ($urandom_range(0, 3) != 0);
        dup_t[p][i] = (off_t[p][i] > 0 && off_t[p][i] < TC && $urandom_range(0, 1) == 1)
                      ? int'($urandom_range(off_t[p][i] + 1, TC)) : 0;
      end
  endtask

  task automatic drive_lanes(input int p, input int idx);
    for (int i = 0; i < N; i++) begin
      if (off_t[p][i] == idx) begin
        phy_phystatus_i[i]         = 1'b1;
        phy_rxstatus_i[3*i +: 3]   = ok_t[p][i] ? 3'b011 : bad_rx();
      end else if (dup_t[p][i] != 0 && dup_t[p][i] == idx) begin
        phy_phystatus_i[i]         = 1'b1;
        phy_rxstatus_i[3*i +: 3]   = ok_t[p][i] ? 3'b000 : 3'b011;
      end else begin
        phy_phystatus_i[i]         = 1'b0;
        phy_rxstatus_i[3*i +: 3]   = 3'($urandom);
      end
    end
  endtask

  task automatic run_case(input string name);
    int exp_np, retries, first, pm, mx, c, exp_mask;
    int exp_dur [NP];
    bit fv, allr, exp_ok, fin, last_tx;
    int win, idx, gap, cyc;

    // Pass-level outcome model
    exp_np = 0; retries = 0; first = 0; fv = 0; exp_ok = 0; exp_mask = 0;
    for (int p = 0; p < NP; p++) exp_dur[p] = 0;
    for (int p = 0; p < NP; p++) begin
      allr = 1'b1; mx = 0; pm = 0;
      for (int i = 0; i < N; i++) begin
        if (off_t[p][i] == 0) allr = 1'b0;
        else if (off_t[p][i] > mx) mx = off_t[p][i];
      end
      exp_dur[p] = allr ? mx : TC;
      for (int i = 0; i < N; i++)
        if (off_t[p][i] > 0 && off_t[p][i] <= exp_dur[p] && ok_t[p][i]) pm |= (1 << i);
      exp_np = p + 1;
      if (fv) begin
        c = pm & first;
        if ((c & 1) != 0) begin exp_ok = 1'b1; exp_mask = c; end
        break;
      end else if ((pm & 1) == 0) begin
        if (retries < RC) retries++;
        else break;
      end else if (pm == (1 << N) - 1) begin
        exp_ok = 1'b1; exp_mask = pm;
        break;
      end else begin
        first = pm; fv = 1'b1;
      end
    end

    en_i = 1'b0;
    phy_phystatus_i = '0;
    @(negedge clk_i);
    en_i = 1'b1;
    win = 0; idx = 0; gap = 0; cyc = 0; fin = 1'b0; last_tx = 1'b0;
    while (!fin && cyc < 1000) begin
      @(negedge clk_i);
      cyc++;
      if (detect_done_o || detect_fail_o) begin
        fin = 1'b1;
        phy_phystatus_i = '0;
      end else if (phy_txdetectrx_o) begin
        if (!last_tx) begin
          check_val($sformatf("%s_quiet%0d", name, win), gap, (win == 0) ? QC : QC + 1);
          win++;
          idx = 0;
        end
        idx++;
        if (win <= NP) drive_lanes(win - 1, idx);
        else phy_phystatus_i = '0;
        last_tx = 1'b1;
      end else begin
        if (last_tx) begin
          check_val($sformatf("%s_win%0d_len", name, win - 1), idx,
                    (win <= NP) ? exp_dur[win - 1] : -1);
          gap = 0;
        end
        if (busy_o) gap++;
        phy_phystatus_i = '0;
        phy_rxstatus_i  = 12'($urandom);
        last_tx = 1'b0;
      end
    end
    check_val({name, "_finished"}, int'(fin), 1);
    check_val({name, "_windows"}, win, exp_np);
    repeat (3) @(negedge clk_i);
    check_val({name, "_done"}, int'(detect_done_o), int'(exp_ok));
    check_val({name, "_fail"}, int'(detect_fail_o), int'(!exp_ok));
    check_val({name, "_mask"}, int'(lane_detected_o), exp_mask);
    check_val({name, "_width"}, int'(num_active_lanes_o), width_model(exp_mask));
    check_val({name, "_busy_tx"}, int'({busy_o, phy_txdetectrx_o}), 0);
    en_i = 1'b0;
    @(negedge clk_i);
    check_val({name, "_cleared"}, all_outs(), 0);
  endtask

  initial begin
    int cyc, seen, busy_seen;

    #1;
    check_val("reset_outs", all_outs(), 0);
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b1;

    // All lanes answer good on DETECT cycle 3
    clear_tables();
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < N; i++) begin off_t[p][i] = 3; ok_t[p][i] = 1'b1; end
    run_case("all_good");

    // Lanes 0-2 good, lane 3 silent on both passes
    clear_tables();
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < 3; i++) begin off_t[p][i] = 2 + 3 * i; ok_t[p][i] = 1'b1; end
    run_case("partial_x2");

    // Nothing answers
    clear_tables();
    run_case("silent");

    // Lane 3 answers on the timeout cycle
    clear_tables();
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < N; i++) begin
        off_t[p][i] = (i == 3) ? TC : i + 1;
        ok_t[p][i]  = 1'b1;
      end
    run_case("late_lane3");

    // Lane 0 answers bad first, good later (must stay failed)
    clear_tables();
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < N; i++) begin
        off_t[p][i] = 1 + i;
        ok_t[p][i]  = (i != 0);
        dup_t[p][i] = (i == 0) ? 6 : 0;
      end
    run_case("dup_ignored");

    for (int t = 0; t < 30; t++) begin
      random_tables();
      run_case($sformatf("rnd%0d", t));
    end

    // en_i dropped mid-DETECT
    en_i = 1'b0;
    @(negedge clk_i);
    en_i = 1'b1;
    cyc = 0; seen = 0;
    while (seen < 2 && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
      if (phy_txdetectrx_o) seen++;
    end
    check_val("abort_reached_detect", seen, 2);
    en_i = 1'b0;
    @(negedge clk_i);
    check_val("abort_outs", all_outs(), 0);

    // Reset pulsed mid-QUIET, then released with en_i held high
    @(negedge clk_i);
    en_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check_val("quiet_busy", int'({busy_o, phy_txdetectrx_o}), 2);
    #2 rst_ni = 1'b0;
    #1;
    check_val("async_reset_outs", all_outs(), 0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (busy_o || detect_done_o || detect_fail_o) busy_seen++;
    end
    check_val("no_start_after_reset", busy_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
